// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper: FSM state encoding
// and the reference AND model used at each sample point.
package gate_sweep_pkg;

    localparam int unsigned MaxIn = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } gts_state_e;

    // Unused upper bits must be driven to 1 by the caller.
    function automatic logic expected_and(input logic [MaxIn-1:0] vec);
        return &vec;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts cycles a stimulus vector has been held; last flags the sample cycle.
module dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign last = (r_cnt == CntW'(DWELL - 1));

endmodule

// File: rtl/gate_truth_sweeper.sv
// Walks every input vector of an N_IN-input AND gate, samples its output at the
// end of each dwell window and counts mismatches. GTS_FAIL_CAPTURE_EN adds
// first-failing-vector capture (fail_vec / fail_valid).
module gate_truth_sweeper
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] a_vec,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
`ifdef GTS_FAIL_CAPTURE_EN
    ,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
`endif
);

    localparam logic [N_IN:0] ErrMax = (N_IN + 1)'(1) << N_IN;

    gts_state_e      r_state;
    logic [N_IN-1:0] r_a_vec;
    logic [N_IN:0]   r_err_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic             w_last;
    logic             w_start_ok;
    logic             w_sample;
    logic             w_mismatch;
    logic [MaxIn-1:0] w_and_arg;
    logic [N_IN:0]    w_err_next;

    assign w_start_ok = start && (r_state != APPLY);
    assign w_sample   = (r_state == APPLY) && w_last;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start_ok || w_sample),
        .en   (r_state == APPLY),
        .last (w_last)
    );

    always_comb begin
        w_and_arg            = '1;
        w_and_arg[N_IN-1:0]  = r_a_vec;
        w_mismatch           = w_sample && (dut_out != expected_and(w_and_arg));
        w_err_next           = r_err_cnt;
        if (w_mismatch && (r_err_cnt != ErrMax)) begin
            w_err_next = r_err_cnt + (N_IN + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a_vec   <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= APPLY;
                        r_a_vec   <= '0;
                        r_err_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                APPLY: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (&r_a_vec) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_a_vec <= r_a_vec + N_IN'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef GTS_FAIL_CAPTURE_EN
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_valid;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
        end else if (w_mismatch && !r_fail_valid) begin
            r_fail_vec   <= r_a_vec;
            r_fail_valid <= 1'b1;
        end
    end

    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;
`endif

    assign a_vec   = r_a_vec;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Self-checking bench for gate_truth_sweeper with a behavioural gate model.
module tb_gate_truth_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] a_vec;
    logic       dut_out;
    logic       busy, done, pass;
    logic [2:0] err_cnt;
    int         gate_mode;  // 0: correct AND, 1: stuck at 0, 2: stuck at 1

    logic       start_b;
    logic [2:0] a_vec_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] err_cnt_b;

`ifdef GTS_FAIL_CAPTURE_EN
    logic [1:0] fail_vec;
    logic       fail_valid;
    logic [2:0] fail_vec_b;
    logic       fail_valid_b;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] sb[$];

    assign dut_out = (gate_mode == 0) ? &a_vec : (gate_mode == 1) ? 1'b0 : 1'b1;

    gate_truth_sweeper #(.N_IN(2), .DWELL(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_vec   (a_vec),
        .dut_out (dut_out),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
`ifdef GTS_FAIL_CAPTURE_EN
        ,
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
`endif
    );

    gate_truth_sweeper #(.N_IN(3), .DWELL(1)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .a_vec   (a_vec_b),
        .dut_out (&a_vec_b),
        .busy    (busy_b),
        .done    (done_b),
        .pass    (pass_b),
        .err_cnt (err_cnt_b)
`ifdef GTS_FAIL_CAPTURE_EN
        ,
        .fail_vec   (fail_vec_b),
        .fail_valid (fail_valid_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gate_model(input int mode, input int v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return (v == 3);
    endfunction

    function automatic int exp_errs(input int mode);
        int e = 0;
        for (int v = 0; v < 4; v++) if (gate_model(mode, v) != (v == 3)) e++;
        return e;
    endfunction

    function automatic int exp_first_fail(input int mode);
        for (int v = 0; v < 4; v++) if (gate_model(mode, v) != (v == 3)) return v;
        return 0;
    endfunction

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if (a_vec !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0
            || err_cnt !== 3'd0) begin
            n_miss++;
            $display("FAIL %s: a_vec=%b busy=%b done=%b pass=%b err_cnt=%0d, required all 0",
                     name, a_vec, busy, done, pass, err_cnt);
        end
`ifdef GTS_FAIL_CAPTURE_EN
        n_vec++;
        if (fail_vec !== 2'b00 || fail_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL %s capture: fail_vec=%b fail_valid=%b, required 00/0",
                     name, fail_vec, fail_valid);
        end
`endif
    endtask

    // Full sweep of dut; optionally pulses start again at APPLY cycle mid_start.
    task automatic run_sweep(input int mode, input int mid_start, input string name);
        int   cyc;
        int   e_err;
        logic [7:0] exp;
        gate_mode = mode;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        for (int v = 0; v < 4; v++) for (int d = 0; d < 4; d++) sb.push_back(8'(v));
        n_vec++;
        if (done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0) begin
            n_miss++;
            $display("FAIL %s start: done=%b pass=%b err_cnt=%0d, required 0/0/0",
                     name, done, pass, err_cnt);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL %s vec cyc %0d: a_vec=%b with no vector expected", name, cyc, a_vec);
            end else begin
                exp = sb.pop_front();
                if (a_vec !== exp[1:0] || busy !== 1'b1) begin
                    n_miss++;
                    $display("FAIL %s vec cyc %0d: a_vec=%b busy=%b, required %b/1",
                             name, cyc, a_vec, busy, exp[1:0]);
                end
            end
            start = (cyc == mid_start);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        e_err = exp_errs(mode);
        n_vec++;
        if (cyc != 16 || sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s length: done after %0d cycles (%0d left), required 16",
                     name, cyc, sb.size());
        end
        sb.delete();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 3'(e_err)
            || pass !== (e_err == 0)) begin
            n_miss++;
            $display("FAIL %s result: done=%b busy=%b err_cnt=%0d pass=%b, required 1/0/%0d/%b",
                     name, done, busy, err_cnt, pass, e_err, (e_err == 0));
        end
`ifdef GTS_FAIL_CAPTURE_EN
        n_vec++;
        if (fail_valid !== (e_err != 0)
            || (e_err != 0 && fail_vec !== 2'(exp_first_fail(mode)))) begin
            n_miss++;
            $display("FAIL %s capture: fail_vec=%b fail_valid=%b, required %0d/%b",
                     name, fail_vec, fail_valid, exp_first_fail(mode), (e_err != 0));
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; gate_mode = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        n_vec++;
        if (a_vec_b !== 3'd0 || busy_b !== 1'b0 || done_b !== 1'b0 || err_cnt_b !== 4'd0) begin
            n_miss++;
            $display("FAIL reset_b: a_vec=%b busy=%b done=%b err_cnt=%0d, required all 0",
                     a_vec_b, busy_b, done_b, err_cnt_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct_and;
        run_sweep(0, -1, "correct");
        repeat (2) @(negedge clk);
        n_vec++;
        if (a_vec !== 2'b11 || done !== 1'b1 || pass !== 1'b1) begin
            n_miss++;
            $display("FAIL done_hold: a_vec=%b done=%b pass=%b, required 11/1/1",
                     a_vec, done, pass);
        end
    endtask

    task automatic test_stuck_faults;
        run_sweep(1, -1, "stuck0");
        run_sweep(0, -1, "restart_ok");
        run_sweep(2, -1, "stuck1");
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        gate_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (a_vec !== 2'b10 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        n_vec++;
        if (a_vec !== 2'b10) begin
            n_miss++;
            $display("FAIL reset_mid reach: a_vec=%b, required 10 within 20 cycles", a_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        run_sweep(0, -1, "after_reset");
    endtask

    task automatic test_back_to_back_start;
        run_sweep(1, 6, "mid_start");
    endtask

    task automatic test_dwell1;
        int cyc = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int v = 0; v < 8; v++) sb.push_back(8'(v));
        while (done_b !== 1'b1 && cyc < 20) begin
            n_vec++;
            if (sb.size() == 0 || a_vec_b !== sb[0][2:0] || busy_b !== 1'b1) begin
                n_miss++;
                $display("FAIL dwell1 vec cyc %0d: a_vec=%b busy=%b, required %0d/1",
                         cyc, a_vec_b, busy_b, cyc);
            end
            if (sb.size() != 0) void'(sb.pop_front());
            cyc++;
            @(negedge clk);
        end
        n_vec++;
        if (cyc != 8 || done_b !== 1'b1 || pass_b !== 1'b1 || err_cnt_b !== 4'd0
            || a_vec_b !== 3'b111) begin
            n_miss++;
            $display("FAIL dwell1 result: cycles=%0d done=%b pass=%b err=%0d a_vec=%b, required 8/1/1/0/111",
                     cyc, done_b, pass_b, err_cnt_b, a_vec_b);
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_correct_and();
        test_stuck_faults();
        test_reset_mid();
        test_back_to_back_start();
        test_dwell1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
